// File: rtl/delay_mem_pkg.sv
// delay_mem_pkg: shared types and defaults for the delay engine sample-memory responder.
//   state_t           : responder FSM state encoding (2 bits)
//   DELAY_DATA_WIDTH  : default sample width, shared with the delay master
//   DELAY_MEMORY_SIZE : default RAM depth in samples, shared with the delay master
//   addr_in_range()   : true when an address lies inside the populated RAM depth
package delay_mem_pkg;

   localparam int DELAY_DATA_WIDTH  = 16;
   localparam int DELAY_MEMORY_SIZE = 8192;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      GUARD = 2'd2,
      CLEAR = 2'd3
   } state_t;

   function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] size);
      return addr < size;
   endfunction

endpackage

// File: rtl/delay_mem_responder_if.sv
// delay_mem_responder_if: sample-memory handshake between the delay master and the responder.
//   master modport drives : mem_write_req, mem_write_addr, mem_data_out,
//                           mem_read_req, mem_read_addr
//   slave modport drives  : mem_data_in, mem_write_ack, mem_read_valid,
//                           mem_ready, mem_addr_error
// Signal names match the master's nets so the two sides wire 1:1.
interface delay_mem_responder_if #(
   parameter int data_width = 16,
   parameter int addr_width = 13
);
   logic                  mem_write_req;
   logic [addr_width-1:0] mem_write_addr;
   logic [data_width-1:0] mem_data_out;
   logic                  mem_read_req;
   logic [addr_width-1:0] mem_read_addr;
   logic [data_width-1:0] mem_data_in;
   logic                  mem_write_ack;
   logic                  mem_read_valid;
   logic                  mem_ready;
   logic                  mem_addr_error;

   modport master (
      output mem_write_req, mem_write_addr, mem_data_out, mem_read_req, mem_read_addr,
      input  mem_data_in, mem_write_ack, mem_read_valid, mem_ready, mem_addr_error
   );

   modport slave (
      input  mem_write_req, mem_write_addr, mem_data_out, mem_read_req, mem_read_addr,
      output mem_data_in, mem_write_ack, mem_read_valid, mem_ready, mem_addr_error
   );
endinterface

// File: rtl/delay_mem_ram.sv
// delay_mem_ram: single-port synchronous RAM, read-first, 1-cycle read latency.
//   clk   in  : clock
//   we    in  : write enable
//   addr  in  : shared read/write address
//   wdata in  : write data
//   q     out : registered read data (old contents on a write cycle)
// Contains no control logic so it maps onto block RAM. Contents are not reset.
module delay_mem_ram #(
   parameter int data_width  = 16,
   parameter int memory_size = 8192
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(memory_size)-1:0] addr,
   input  logic [data_width-1:0]          wdata,
   output logic [data_width-1:0]          q
);
   logic [data_width-1:0] r_mem [memory_size];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
      q <= r_mem[addr];
   end
endmodule

// File: rtl/delay_mem_responder.sv
// delay_mem_responder: memory-side responder for the delay engine's sample-memory handshake.
//   clk     in  : system clock
//   reset_n in  : asynchronous active-low reset
//   bus     slave modport of delay_mem_responder_if:
//      mem_write_req/addr, mem_data_out : level-held write request from the master
//      mem_read_req/addr                : level-held read request from the master
//      mem_write_ack                    : 1-cycle pulse, write committed
//      mem_read_valid, mem_data_in      : 1-cycle pulse, read data valid (data held afterwards)
//      mem_ready                        : requests being accepted (state != CLEAR)
//      mem_addr_error                   : 1-cycle pulse with ack/valid when address >= memory_size
// Optional feature macro DELAY_MEM_CLEAR_EN: zero-fill sweep of the RAM after every reset
// release, during which mem_ready is low and requests wait.
module delay_mem_responder
   import delay_mem_pkg::*;
#(
   parameter int data_width  = DELAY_DATA_WIDTH,
   parameter int memory_size = DELAY_MEMORY_SIZE
) (
   input  logic                 clk,
   input  logic                 reset_n,
   delay_mem_responder_if.slave bus
);
   localparam int addr_width = $clog2(memory_size);

   state_t                r_state;
   logic                  r_write_ack;
   logic                  r_read_valid;
   logic                  r_addr_error;
   logic                  r_rd_err;
   logic [data_width-1:0] r_data_in;
`ifdef DELAY_MEM_CLEAR_EN
   logic [addr_width-1:0] r_clr_addr;
`endif

   logic                  w_we;
   logic [addr_width-1:0] w_ram_addr;
   logic [data_width-1:0] w_wdata;
   logic [data_width-1:0] w_ram_q;
   logic                  w_wr_in_range;
   logic                  w_rd_in_range;

   assign w_wr_in_range = addr_in_range(32'(bus.mem_write_addr), 32'(memory_size));
   assign w_rd_in_range = addr_in_range(32'(bus.mem_read_addr), 32'(memory_size));

   // The RAM reads its address every edge, so pointing it at the read address in IDLE
   // is what loads ram_q for the READ cycle. reset_n gates we so an edge during reset
   // can never commit a write.
   always_comb begin
      w_we       = 1'b0;
      w_ram_addr = bus.mem_read_addr;
      w_wdata    = bus.mem_data_out;
      case (r_state)
         IDLE: begin
            if (bus.mem_write_req) begin
               w_ram_addr = bus.mem_write_addr;
               w_we       = w_wr_in_range & reset_n;
            end
         end
`ifdef DELAY_MEM_CLEAR_EN
         CLEAR: begin
            w_ram_addr = r_clr_addr;
            w_wdata    = '0;
            w_we       = reset_n;
         end
`endif
         default: ;
      endcase
   end

   delay_mem_ram #(
      .data_width (data_width),
      .memory_size(memory_size)
   ) u_ram (
      .clk  (clk),
      .we   (w_we),
      .addr (w_ram_addr),
      .wdata(w_wdata),
      .q    (w_ram_q)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
`ifdef DELAY_MEM_CLEAR_EN
         r_state    <= CLEAR;
         r_clr_addr <= '0;
`else
         r_state    <= IDLE;
`endif
         r_write_ack  <= 1'b0;
         r_read_valid <= 1'b0;
         r_addr_error <= 1'b0;
         r_rd_err     <= 1'b0;
         r_data_in    <= '0;
      end else begin
         r_write_ack  <= 1'b0;
         r_read_valid <= 1'b0;
         r_addr_error <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.mem_write_req) begin
                  r_write_ack  <= 1'b1;
                  r_addr_error <= ~w_wr_in_range;
                  r_state      <= GUARD;
               end else if (bus.mem_read_req) begin
                  r_rd_err <= ~w_rd_in_range;
                  r_state  <= READ;
               end
            end
            READ: begin
               r_data_in    <= r_rd_err ? '0 : w_ram_q;
               r_read_valid <= 1'b1;
               r_addr_error <= r_rd_err;
               r_state      <= GUARD;
            end
            // Master still shows req on the cycle after ack/valid; ignore it here.
            GUARD: r_state <= IDLE;
`ifdef DELAY_MEM_CLEAR_EN
            CLEAR: begin
               if (r_clr_addr == addr_width'(memory_size - 1)) begin
                  r_state <= IDLE;
               end else begin
                  r_clr_addr <= r_clr_addr + 1'b1;
               end
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.mem_data_in    = r_data_in;
   assign bus.mem_write_ack  = r_write_ack;
   assign bus.mem_read_valid = r_read_valid;
   assign bus.mem_addr_error = r_addr_error;
   assign bus.mem_ready      = (r_state != CLEAR);
endmodule

// File: tb/tb_delay_mem_responder.sv
// tb_delay_mem_responder: directed bench for delay_mem_responder (memory_size = 6000).
// Table of write/read transactions with hand-computed results, plus hand-written
// sequences for simultaneous requests, req held through GUARD, and reset mid-read.
// With DELAY_MEM_CLEAR_EN defined it also checks the post-reset zero sweep.
module tb_delay_mem_responder;
   localparam int DW  = 16;
   localparam int MS  = 6000;
   localparam int AW  = 13;

   logic clk;
   logic reset_n;
   int   n_checks = 0;
   int   n_err    = 0;

   delay_mem_responder_if #(.data_width(DW), .addr_width(AW)) bus ();

   delay_mem_responder #(
      .data_width (DW),
      .memory_size(MS)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit              wr;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
      logic [DW-1:0]   exp_data;
      bit              exp_err;
      int              exp_lat;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Raise write req in IDLE, hold until ack, then let GUARD pass.
   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           output int lat, output logic err);
      lat = 99;
      err = 1'bx;
      bus.mem_write_addr = addr;
      bus.mem_data_out   = data;
      bus.mem_write_req  = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (bus.mem_write_ack) begin
            lat = c;
            err = bus.mem_addr_error;
            break;
         end
      end
      bus.mem_write_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [AW-1:0] addr, output int lat,
                          output logic [DW-1:0] data, output logic err);
      lat  = 99;
      err  = 1'bx;
      data = 'x;
      bus.mem_read_addr = addr;
      bus.mem_read_req  = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (bus.mem_read_valid) begin
            lat  = c;
            data = bus.mem_data_in;
            err  = bus.mem_addr_error;
            break;
         end
      end
      bus.mem_read_req = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int            lat;
      logic          err;
      logic [DW-1:0] rd;
      int            n_ack;
      int            n_val;
      int            ack_c;
      int            val_c;
      logic [DW-1:0] val_d;

      vecs[0] = '{1'b1, 13'h0010, 16'h1234, 16'h0000, 1'b0, 1};
      vecs[1] = '{1'b0, 13'h0010, 16'h0000, 16'h1234, 1'b0, 2};
      vecs[2] = '{1'b1, 13'h0FFF, 16'h8000, 16'h0000, 1'b0, 1};
      vecs[3] = '{1'b0, 13'h0FFF, 16'h0000, 16'h8000, 1'b0, 2};
      vecs[4] = '{1'b0, 13'd6000, 16'h0000, 16'h0000, 1'b1, 2};
      vecs[5] = '{1'b1, 13'd6001, 16'hBEEF, 16'h0000, 1'b1, 1};
      vecs[6] = '{1'b1, 13'd5999, 16'h00AA, 16'h0000, 1'b0, 1};
      vecs[7] = '{1'b0, 13'd5999, 16'h0000, 16'h00AA, 1'b0, 2};
      vecs[8] = '{1'b0, 13'h0010, 16'h0000, 16'h1234, 1'b0, 2};
      vecs[9] = '{1'b0, 13'h0FFF, 16'h0000, 16'h8000, 1'b0, 2};

      reset_n            = 1'b0;
      bus.mem_write_req  = 1'b0;
      bus.mem_read_req   = 1'b0;
      bus.mem_write_addr = '0;
      bus.mem_read_addr  = '0;
      bus.mem_data_out   = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_ack",   32'(bus.mem_write_ack),  32'd0);
      check("reset_valid", 32'(bus.mem_read_valid), 32'd0);
      check("reset_err",   32'(bus.mem_addr_error), 32'd0);
      check("reset_data",  32'(bus.mem_data_in),    32'd0);

`ifdef DELAY_MEM_CLEAR_EN
      // Write req held across the sweep; it must be acked only once ready rises.
      bus.mem_write_addr = 13'h0030;
      bus.mem_data_out   = 16'h5555;
      bus.mem_write_req  = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      ack_c = 0;
      val_c = 0;
      for (int c = 1; c <= MS + 20; c++) begin
         @(posedge clk); #1;
         if (val_c == 0 && bus.mem_ready) val_c = c;
         if (bus.mem_write_ack) begin
            ack_c = c;
            break;
         end
      end
      bus.mem_write_req = 1'b0;
      check("clear_ready_low_cycles", 32'(val_c), 32'(MS));
      check("clear_held_write_ack",   32'(ack_c), 32'(MS + 1));
      @(posedge clk); #1;
      do_read(13'h0040, lat, rd, err);
      check("clear_unwritten_read", 32'(rd), 32'h0000);
`else
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("ready_after_release", 32'(bus.mem_ready), 32'd1);
      @(posedge clk); #1;
`endif

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            do_write(vecs[i].addr, vecs[i].data, lat, err);
            check($sformatf("v%0d_wr_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_wr_err", i), 32'(err), 32'(vecs[i].exp_err));
         end else begin
            do_read(vecs[i].addr, lat, rd, err);
            check($sformatf("v%0d_rd_lat", i),  32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_rd_data", i), 32'(rd),  32'(vecs[i].exp_data));
            check($sformatf("v%0d_rd_err", i),  32'(err), 32'(vecs[i].exp_err));
         end
      end

      // Read data holds between reads.
      repeat (3) @(posedge clk);
      #1;
      check("data_hold", 32'(bus.mem_data_in), 32'h8000);

      // Both requests at once: write first, read after GUARD.
      bus.mem_write_addr = 13'd5;
      bus.mem_data_out   = 16'h7FFF;
      bus.mem_read_addr  = 13'd5;
      bus.mem_write_req  = 1'b1;
      bus.mem_read_req   = 1'b1;
      n_ack = 0; n_val = 0; ack_c = 0; val_c = 0; val_d = '0;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (bus.mem_write_ack) begin
            n_ack++;
            ack_c = c;
            bus.mem_write_req = 1'b0;
         end
         if (bus.mem_read_valid) begin
            n_val++;
            val_c = c;
            val_d = bus.mem_data_in;
            bus.mem_read_req = 1'b0;
         end
      end
      check("both_ack_cycle",  32'(ack_c), 32'd1);
      check("both_ack_count",  32'(n_ack), 32'd1);
      check("both_val_cycle",  32'(val_c), 32'd4);
      check("both_val_count",  32'(n_val), 32'd1);
      check("both_read_data",  32'(val_d), 32'h7FFF);

      // Write req held one cycle past the ack (through GUARD): still one ack.
      bus.mem_write_addr = 13'h0020;
      bus.mem_data_out   = 16'h1111;
      bus.mem_write_req  = 1'b1;
      n_ack = 0; ack_c = 0;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (bus.mem_write_ack) begin
            n_ack++;
            ack_c = c;
         end
         if (ack_c != 0 && c == ack_c + 1) bus.mem_write_req = 1'b0;
      end
      check("hold_ack_count", 32'(n_ack), 32'd1);

      // No response while requests are low, nor to a req dropped between edges.
      n_ack = 0; n_val = 0;
      for (int c = 1; c <= 6; c++) begin
         if (c == 2) begin
            bus.mem_read_addr = 13'h0010;
            bus.mem_read_req  = 1'b1;
            #3;
            bus.mem_read_req  = 1'b0;
         end
         @(posedge clk); #1;
         if (bus.mem_write_ack)  n_ack++;
         if (bus.mem_read_valid) n_val++;
      end
      check("idle_no_ack",   32'(n_ack), 32'd0);
      check("idle_no_valid", 32'(n_val), 32'd0);

      do_read(13'h0020, lat, rd, err);
      check("hold_write_data", 32'(rd), 32'h1111);

      // Reset asserted while in READ: outputs clear at once, no late valid.
      bus.mem_read_addr = 13'h0010;
      bus.mem_read_req  = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_pre_valid", 32'(bus.mem_read_valid), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async_data",  32'(bus.mem_data_in),    32'd0);
      check("rst_async_valid", 32'(bus.mem_read_valid), 32'd0);
      bus.mem_read_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
`ifdef DELAY_MEM_CLEAR_EN
      for (int c = 1; c <= MS + 20; c++) begin
         @(posedge clk); #1;
         if (bus.mem_ready) break;
      end
`endif
      n_val = 0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         if (bus.mem_read_valid) n_val++;
      end
      check("rst_no_late_valid", 32'(n_val), 32'd0);
      do_read(13'h0010, lat, rd, err);
      check("rst_next_read_lat", 32'(lat), 32'd2);
`ifdef DELAY_MEM_CLEAR_EN
      check("rst_next_read_data", 32'(rd), 32'h0000);
`else
      check("rst_next_read_data", 32'(rd), 32'h1234);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
